// File: rtl/button_reader_if.sv
// Bundle of the user-input lines between board pins and control logic:
// raw buttons in, clean levels, edge pulses, press count and long-press out.
interface button_reader_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] BTN;
  logic [WIDTH-1:0] DB;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic [CNT_W-1:0] PRESS_CNT;
  logic [WIDTH-1:0] LONG;

  modport master (output BTN, input DB, RISE, FALL, PRESS_CNT, LONG);
  modport slave  (input BTN, output DB, RISE, FALL, PRESS_CNT, LONG);
endinterface

// File: rtl/button_reader.sv
// Synchronizes and debounces WIDTH button lines on a shared prescaled tick.
// Long-press detection is built only when BUTTON_READER_LONG_PRESS_EN is defined.
module button_reader #(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 1024,
  parameter int STABLE_TICKS = 4,
  parameter int CNT_W        = 16,
  parameter int LONG_TICKS   = 512
) (
  input  logic            CLK,
  input  logic            RST,
  button_reader_if.slave  bus
);

  localparam int DW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);

  typedef enum logic {STABLE = 1'b0, CHANGING = 1'b1} state_e;

  if (TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_params
    $error("button_reader: illegal parameter value");
  end

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [DW-1:0]    div_r;
  logic             tick_s;
  state_e           state_r [WIDTH];
  logic [SW-1:0]    stab_r  [WIDTH];
  logic [WIDTH-1:0] db_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] long_r;

  // Two-flop synchronizer for the asynchronous pins
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_r <= {WIDTH{1'b0}};
      s2_r <= {WIDTH{1'b0}};
    end else begin
      s1_r <= bus.BTN;
      s2_r <= s1_r;
    end
  end

  // Free-running sample divider shared by every line
  always_ff @(posedge CLK) begin
    if (!RST) begin
      div_r <= {DW{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_r <= {DW{1'b0}};
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  assign tick_s = (div_r == DIV_LAST);

  // Per-line debounce FSM; the accepted level and its edge pulse update together
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_r[i] <= STABLE;
        stab_r[i]  <= {SW{1'b0}};
      end
      db_r   <= {WIDTH{1'b0}};
      rise_r <= {WIDTH{1'b0}};
      fall_r <= {WIDTH{1'b0}};
    end else begin
      rise_r <= {WIDTH{1'b0}};
      fall_r <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        if (tick_s) begin
          case (state_r[i])
            STABLE: begin
              if (s2_r[i] != db_r[i]) begin
                if (STAB_ONE == STAB_LAST) begin
                  db_r[i]   <= s2_r[i];
                  rise_r[i] <= s2_r[i];
                  fall_r[i] <= ~s2_r[i];
                  stab_r[i] <= {SW{1'b0}};
                end else begin
                  state_r[i] <= CHANGING;
                  stab_r[i]  <= STAB_ONE;
                end
              end else begin
                state_r[i] <= STABLE;
              end
            end
            CHANGING: begin
              if (s2_r[i] == db_r[i]) begin
                state_r[i] <= STABLE;
                stab_r[i]  <= {SW{1'b0}};
              end else if (stab_r[i] + STAB_ONE == STAB_LAST) begin
                db_r[i]    <= s2_r[i];
                rise_r[i]  <= s2_r[i];
                fall_r[i]  <= ~s2_r[i];
                stab_r[i]  <= {SW{1'b0}};
                state_r[i] <= STABLE;
              end else begin
                stab_r[i] <= stab_r[i] + STAB_ONE;
              end
            end
            default: begin
              state_r[i] <= STABLE;
              stab_r[i]  <= {SW{1'b0}};
            end
          endcase
        end else begin
          state_r[i] <= state_r[i];
        end
      end
    end
  end

  // Press counter lags RISE by one cycle and wraps freely
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + popcount(rise_r);
    end
  end

`ifdef BUTTON_READER_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic [HW-1:0] hold_r [WIDTH];

  // Hold counters saturate, so each press yields at most one LONG pulse
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < WIDTH; i++) begin
        hold_r[i] <= {HW{1'b0}};
      end
      long_r <= {WIDTH{1'b0}};
    end else begin
      long_r <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        if (!db_r[i]) begin
          hold_r[i] <= {HW{1'b0}};
        end else if (tick_s && hold_r[i] != HOLD_LAST) begin
          hold_r[i] <= hold_r[i] + HOLD_ONE;
          long_r[i] <= (hold_r[i] + HOLD_ONE == HOLD_LAST);
        end else begin
          hold_r[i] <= hold_r[i];
        end
      end
    end
  end
`else
  // Long-press detection not built: output held low
  always_ff @(posedge CLK) begin
    if (!RST) begin
      long_r <= {WIDTH{1'b0}};
    end else begin
      long_r <= {WIDTH{1'b0}};
    end
  end
`endif

  assign bus.DB        = db_r;
  assign bus.RISE      = rise_r;
  assign bus.FALL      = fall_r;
  assign bus.PRESS_CNT = cnt_r;
  assign bus.LONG      = long_r;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: edge events are queued as buttons are driven
// and matched against RISE/FALL pulses, with latency, level and count checks.
module tb_button_reader;
  localparam int W  = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int CW = 4;
  localparam int LT = 5;
  localparam int LAT_LO = 2 + (ST - 1) * TD + 1;
  localparam int LAT_HI = 2 + ST * TD;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  button_reader_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  button_reader #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .CNT_W(CW), .LONG_TICKS(LT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int           lo;
    int           hi;
  } ev_t;

  ev_t          sbq[$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_bad = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [W-1:0] exp_db = '0;
  bit           cnt_pending = 1'b0;
  int           long_cnt = 0;
  int           long_cyc = 0;
  int           rise0_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] pop2(input logic [W-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  task automatic expect_edge(input logic [W-1:0] r, input logic [W-1:0] f);
    ev_t e;
    e.rise = r;
    e.fall = f;
    e.lo   = cyc + LAT_LO;
    e.hi   = cyc + LAT_HI;
    sbq.push_back(e);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && sbq.size() != 0; k++) @(negedge CLK);
    @(negedge CLK);
    if (sbq.size() != 0) begin
      check_val("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic press(input logic [W-1:0] v);
    logic [W-1:0] cur;
    @(negedge CLK);
    cur = bus.BTN;
    bus.BTN = v;
    expect_edge(v & ~cur, ~v & cur);
    wait_drain();
  endtask

  // Output monitor: pops the scoreboard on every pulse
  always @(negedge CLK) begin
    ev_t e;
    if (RST) begin
      if (cnt_pending) begin
        check_val("press_cnt", bus.PRESS_CNT, exp_cnt);
        cnt_pending = 1'b0;
      end
      if (bus.LONG != '0) begin
        long_cnt++;
        long_cyc = cyc;
      end
      if ((bus.RISE | bus.FALL) != '0) begin
        if (sbq.size() == 0) begin
          check_val("unexp_pulse", {bus.RISE, bus.FALL}, 0);
        end else begin
          e = sbq.pop_front();
          check_val("pulse", {bus.RISE, bus.FALL}, {e.rise, e.fall});
          check_val("latency", (cyc >= e.lo && cyc <= e.hi), 1);
          exp_db = (exp_db | e.rise) & ~e.fall;
          check_val("db", bus.DB, exp_db);
          exp_cnt = exp_cnt + pop2(e.rise);
          cnt_pending = 1'b1;
          if (e.rise[0]) rise0_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int exp_long;
`ifdef BUTTON_READER_LONG_PRESS_EN
    exp_long = 1;
`else
    exp_long = 0;
`endif
    bus.BTN = '0;
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check_val("rst_db", bus.DB, 0);
    check_val("rst_rise", bus.RISE, 0);
    check_val("rst_fall", bus.FALL, 0);
    check_val("rst_cnt", bus.PRESS_CNT, 0);
    check_val("rst_long", bus.LONG, 0);
    RST = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      check_val("tick", dut.tick_s, ((k % TD) == TD - 1) ? 1 : 0);
    end

    press(2'b01);

    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (k % 3 == 0) bus.BTN[1] = ~bus.BTN[1];
    end
    bus.BTN[1] = 1'b0;
    repeat (24) @(negedge CLK);
    check_val("bounce_db", bus.DB, exp_db);
    check_val("bounce_cnt", bus.PRESS_CNT, exp_cnt);
    check_val("bounce_sb", sbq.size(), 0);

    press(2'b00);
    press(2'b11);
    for (int k = 0; k < 7; k++) begin
      press(2'b00);
      press(2'b11);
    end
    check_val("cnt_wrap", bus.PRESS_CNT, 32'(4'(1 + 2 * 8)));

    press(2'b00);
    @(negedge CLK);
    bus.BTN = 2'b01;
    repeat (9) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("mid_rst_db", bus.DB, 0);
    check_val("mid_rst_rise", bus.RISE, 0);
    check_val("mid_rst_fall", bus.FALL, 0);
    check_val("mid_rst_cnt", bus.PRESS_CNT, 0);
    check_val("mid_rst_long", bus.LONG, 0);
    exp_cnt  = '0;
    exp_db   = '0;
    long_cnt = 0;
    RST = 1'b1;
    expect_edge(2'b01, 2'b00);
    wait_drain();

    repeat (40 * TD) @(negedge CLK);
    check_val("long_count", long_cnt, exp_long);
    check_val("long_delay", (long_cnt == 0) ? 0 : long_cyc - rise0_cyc, exp_long * LT * TD);
    check_val("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
